// File: rtl/show_corrode_ram_ctrl.sv
//============================================================================
// Module      : show_corrode_ram_ctrl
// Description : Write/read sequencer for the decimated 1-bit corrode mask RAM
//               (clear, frame capture, independent display read port).
// Revision    : 1.0
//============================================================================
`default_nettype none

module show_corrode_ram_ctrl #(
    parameter int SRC_W    = 1024,
    parameter int SRC_H    = 512,
    parameter int DS_SHIFT = 3,
    parameter int ADDR_W   = 13,
    localparam int XW      = $clog2(SRC_W),
    localparam int YW      = $clog2(SRC_H),
    localparam int GX_W    = XW - DS_SHIFT,
    localparam int GY_W    = YW - DS_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              cap_req,
    output logic              busy,
    output logic              done,
    input  logic              in_vs,
    input  logic              in_de,
    input  logic              in_bit,
    input  logic              rd_en,
    input  logic [GX_W-1:0]   rd_x,
    input  logic [GY_W-1:0]   rd_y,
    output logic              rd_bit,
    output logic              rd_vld,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic              ram_din,
    output logic              ram_ceb,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_oce,
    output logic              ram_reset,
    input  logic              ram_dout
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [XW-1:0]     SX_LAST   = XW'(SRC_W - 1);
    localparam logic [YW-1:0]     SY_LAST   = YW'(SRC_H - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_WAIT_VS = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_sx;
    logic [YW-1:0]   r_sy;

    logic              w_sample;
    logic              w_last_px;
    logic [ADDR_W-1:0] w_cap_addr;

    // Only the top-left source pixel of each DS x DS block is stored.
    assign w_sample   = (r_sx[DS_SHIFT-1:0] == '0) && (r_sy[DS_SHIFT-1:0] == '0);
    assign w_last_px  = (r_sx == SX_LAST) && (r_sy == SY_LAST);
    assign w_cap_addr = {r_sy[YW-1:DS_SHIFT], r_sx[XW-1:DS_SHIFT]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            ram_cea <= 1'b0;
            ram_din <= 1'b0;
            ram_ada <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
        end else begin
            done    <= 1'b0;
            ram_cea <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        busy    <= 1'b1;
                        ram_cea <= 1'b1;
                        ram_din <= 1'b0;
                        ram_ada <= '0;
                    end else if (cap_req) begin
                        r_state <= S_WAIT_VS;
                        busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (ram_ada == LAST_ADDR) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        ram_cea <= 1'b1;
                        ram_ada <= ram_ada + ADDR_W'(1);
                    end
                end
                S_WAIT_VS: begin
                    if (in_vs) begin
                        r_state <= S_CAPTURE;
                        r_sx    <= '0;
                        r_sy    <= '0;
                    end
                end
                S_CAPTURE: begin
                    // A frame-start inside a capture restarts the frame silently.
                    if (in_vs) begin
                        r_sx <= '0;
                        r_sy <= '0;
                    end else if (in_de) begin
                        if (w_sample) begin
                            ram_cea <= 1'b1;
                            ram_ada <= w_cap_addr;
                            ram_din <= in_bit;
                        end
                        if (r_sx == SX_LAST) begin
                            r_sx <= '0;
                            r_sy <= r_sy + YW'(1);
                        end else begin
                            r_sx <= r_sx + XW'(1);
                        end
                        if (w_last_px) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Read port runs regardless of the write-side state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_ceb <= 1'b0;
            ram_adb <= '0;
            rd_vld  <= 1'b0;
        end else begin
            ram_ceb <= rd_en;
            rd_vld  <= ram_ceb;
            if (rd_en) begin
                ram_adb <= {rd_y, rd_x};
            end
        end
    end

    assign rd_bit    = ram_dout;
    assign ram_oce   = 1'b1;
    assign ram_reset = ~rst_n;

endmodule

`default_nettype wire

// File: tb/tb_show_corrode_ram_ctrl.sv
//============================================================================
// Module      : tb_show_corrode_ram_ctrl
// Description : Scoreboard bench for show_corrode_ram_ctrl on a reduced
//               128x128 source (16x16 grid) with a 1-bit bypass RAM model.
// Revision    : 1.0
//============================================================================
`default_nettype none

module tb_show_corrode_ram_ctrl;

    localparam int SRC_W    = 128;
    localparam int SRC_H    = 128;
    localparam int DS_SHIFT = 3;
    localparam int ADDR_W   = 8;
    localparam int GX_W     = 4;
    localparam int GY_W     = 4;
    localparam int NADDR    = 1 << ADDR_W;
    localparam int M_NONE   = 0;
    localparam int M_CLR    = 1;
    localparam int M_CAP    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_req = 1'b0, cap_req = 1'b0;
    logic in_vs = 1'b0, in_de = 1'b0, in_bit = 1'b0, rd_en = 1'b0;
    logic [GX_W-1:0] rd_x = '0;
    logic [GY_W-1:0] rd_y = '0;
    logic busy, done, rd_bit, rd_vld, ram_cea, ram_din, ram_ceb, ram_oce, ram_reset;
    logic [ADDR_W-1:0] ram_ada, ram_adb;
    logic ram_dout = 1'b0;

    always #5 clk = ~clk;

    show_corrode_ram_ctrl #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .DS_SHIFT(DS_SHIFT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .cap_req(cap_req),
        .busy(busy), .done(done), .in_vs(in_vs), .in_de(in_de), .in_bit(in_bit),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_bit(rd_bit), .rd_vld(rd_vld),
        .ram_cea(ram_cea), .ram_ada(ram_ada), .ram_din(ram_din),
        .ram_ceb(ram_ceb), .ram_adb(ram_adb), .ram_oce(ram_oce),
        .ram_reset(ram_reset), .ram_dout(ram_dout)
    );

    // Bypass-mode SDPB: registered read, old data on same-address collision.
    logic mem [NADDR];
    always @(posedge clk) begin
        if (ram_cea) mem[ram_ada] <= ram_din;
        if (ram_reset) ram_dout <= 1'b0;
        else if (ram_ceb) ram_dout <= mem[ram_adb];
    end

    typedef struct {int due; logic exp;} rd_t;
    typedef struct {logic [ADDR_W-1:0] a; logic d;} wr_t;
    rd_t rdq[$];
    wr_t wrq[$];
    logic model [NADDR];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, mode = M_NONE;
    int clr_next = 0, done_cnt = 0, busy_cnt = 0;
    logic prev_done = 1'b0, prev_cea = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        rd_t r;
        wr_t w;
        int exp_a;
        if (rd_vld) begin
            if (rdq.size() == 0) check("rd_unexpected", 1, 0);
            else begin
                r = rdq.pop_front();
                check("rd_time", cyc, r.due);
                check("rd_bit", rd_bit, r.exp);
            end
        end
        if (ram_cea) begin
            if (mode == M_CLR) begin
                exp_a = prev_cea ? clr_next : 0;
                check("clr_addr", ram_ada, exp_a);
                check("clr_din", ram_din, 0);
                clr_next <= exp_a + 1;
            end else if (mode == M_CAP) begin
                if (wrq.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    w = wrq.pop_front();
                    check("wr_addr", ram_ada, w.a);
                    check("wr_din", ram_din, w.d);
                end
            end else begin
                check("wr_idle", 1, 0);
            end
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            check("done_pulse", prev_done, 0);
        end
        busy_cnt  <= busy_cnt + (busy ? 1 : 0);
        prev_done <= done;
        prev_cea  <= ram_cea;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        check(tag, done_cnt != d0, 1);
    endtask

    task automatic rd_issue(input int a, input logic exp);
        rd_t r;
        rd_en = 1'b1;
        rd_x  = GX_W'(a % (1 << GX_W));
        rd_y  = GY_W'(a >> GX_W);
        r.due = cyc + 2;
        r.exp = exp;
        rdq.push_back(r);
        step();
    endtask

    task automatic rd_drain();
        rd_en = 1'b0;
        repeat (4) step();
        check("rd_drain", rdq.size(), 0);
    endtask

    task automatic drive_frame(input int lines, input bit rnd);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < SRC_W; x++) begin
                logic b;
                wr_t w;
                b = rnd ? 1'($urandom_range(1)) : 1'(((x >> 3) ^ (y >> 3)) & 1);
                in_de  = 1'b1;
                in_bit = b;
                if ((x % 8) == 0 && (y % 8) == 0) begin
                    w.a = ADDR_W'(((y >> 3) << GX_W) | (x >> 3));
                    w.d = b;
                    wrq.push_back(w);
                    model[w.a] = b;
                end
                step();
            end
            in_de  = 1'b0;
            in_bit = 1'b0;
            step();
        end
    endtask

    task automatic run_clear(input string tag);
        int d0 = done_cnt;
        int b0 = busy_cnt;
        mode = M_CLR;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_done({tag, "_done"}, d0, NADDR + 20);
        mode = M_NONE;
        repeat (3) step();
        check({tag, "_busy_cycles"}, busy_cnt - b0, NADDR);
        check({tag, "_writes"}, clr_next, NADDR);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        for (int a = 0; a < NADDR; a++) model[a] = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int b0;

        repeat (3) step();
        check("rst_ram_reset_hi", ram_reset, 1);
        rst_n = 1'b1;
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_vld", rd_vld, 0);
        check("rst_cea", ram_cea, 0);
        check("rst_ceb", ram_ceb, 0);
        check("rst_din", ram_din, 0);
        check("rst_ada", ram_ada, 0);
        check("rst_adb", ram_adb, 0);
        check("rst_oce", ram_oce, 1);
        check("rst_ram_reset_lo", ram_reset, 0);

        // Clear, then every address reads zero.
        run_clear("clr");
        for (int a = 0; a < NADDR; a++) rd_issue(a, 1'b0);
        rd_drain();

        // Checkerboard capture; in_de while waiting for vs must not write.
        d0 = done_cnt;
        mode = M_CAP;
        cap_req = 1'b1;
        step();
        cap_req = 1'b0;
        check("cap_busy", busy, 1);
        in_de = 1'b1;
        in_bit = 1'b1;
        repeat (5) step();
        in_de = 1'b0;
        in_bit = 1'b0;
        in_vs = 1'b1;
        step();
        in_vs = 1'b0;
        drive_frame(SRC_H, 1'b0);
        wait_done("cap_done", d0, 10);
        repeat (2) step();
        check("cap_done_count", done_cnt - d0, 1);
        check("cap_idle", busy, 0);
        check("cap_wr_left", wrq.size(), 0);
        mode = M_NONE;
        rd_issue(1, 1'b1);
        rd_issue(0, 1'b0);
        rd_issue((1 << GX_W) + 1, 1'b0);
        for (int a = 0; a < NADDR; a++) rd_issue(a, model[a]);
        rd_drain();

        // Four back-to-back reads, in request order.
        for (int a = 0; a < 4; a++) rd_issue(a, model[a]);
        rd_drain();

        // Simultaneous requests: clear wins; requests while busy are dropped.
        d0 = done_cnt;
        b0 = busy_cnt;
        mode = M_CLR;
        clr_req = 1'b1;
        cap_req = 1'b1;
        step();
        clr_req = 1'b0;
        cap_req = 1'b0;
        repeat (50) step();
        cap_req = 1'b1;
        step();
        cap_req = 1'b0;
        repeat (50) step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wait_done("both_done", d0, NADDR + 20);
        mode = M_NONE;
        repeat (5) step();
        check("both_writes", clr_next, NADDR);
        check("both_busy_cycles", busy_cnt - b0, NADDR);
        check("both_done_count", done_cnt - d0, 1);
        check("both_idle", busy, 0);
        for (int a = 0; a < NADDR; a++) model[a] = 1'b0;
        rd_issue(1, 1'b0);
        rd_issue(NADDR - 1, 1'b0);
        rd_drain();

        // Resync at line 100, then a full random frame.
        d0 = done_cnt;
        mode = M_CAP;
        cap_req = 1'b1;
        step();
        cap_req = 1'b0;
        step();
        in_vs = 1'b1;
        step();
        in_vs = 1'b0;
        drive_frame(100, 1'b1);
        check("resync_no_done", done_cnt - d0, 0);
        check("resync_busy", busy, 1);
        in_vs = 1'b1;
        step();
        in_vs = 1'b0;
        drive_frame(SRC_H, 1'b1);
        wait_done("resync_done", d0, 10);
        repeat (5) step();
        check("resync_done_count", done_cnt - d0, 1);
        check("resync_wr_left", wrq.size(), 0);
        check("resync_idle", busy, 0);
        mode = M_NONE;
        for (int a = 0; a < NADDR; a++) rd_issue(a, model[a]);
        rd_drain();

        // Reset in the middle of a clear.
        d0 = done_cnt;
        mode = M_CLR;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (200) step();
        check("midclr_addr", ram_ada, 200);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midclr_rst_busy", busy, 0);
        check("midclr_rst_cea", ram_cea, 0);
        mode = M_NONE;
        repeat (NADDR) step();
        check("midclr_no_done", done_cnt - d0, 0);
        check("midclr_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
